// File: rtl/bus_arbiter_mux.sv
// Registered N-to-1 bus multiplexer with direct select or round-robin arbitration.
// A loaded word is held on Bus until the consumer takes it with bus_ready.
module bus_arbiter_mux #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       req,
  input  logic                  mode,
  input  logic [SELW-1:0]       Src,
  input  logic                  sel_en,
  input  logic                  bus_ready,
  output logic [WIDTH-1:0]      Bus,
  output logic                  bus_valid,
  output logic [NSRC-1:0]       grant,
  output logic [SELW-1:0]       grant_idx,
  output logic                  sel_err
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [NSRC-1:0] GRANT_ONE = {{(NSRC-1){1'b0}}, 1'b1};
  localparam logic [SELW-1:0] LAST_RST  = SELW'(NSRC - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  bus_q;
  logic [NSRC-1:0]   grant_q;
  logic [SELW-1:0]   grant_idx_q;
  logic              sel_err_q;
  logic [SELW-1:0]   last_q;

  logic              eval;
  logic              src_ok;
  logic              load_d;
  logic              sel_err_d;
  logic [SELW-1:0]   idx_d;
  logic [WIDTH-1:0]  bus_d;
  logic [31:0]       src_ext;

  logic              hi_found, lo_found;
  logic [SELW-1:0]   hi_idx, lo_idx;

  // Round-robin: lowest requester above last wins, else lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = SELW'(i);
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = SELW'(i);
        end
      end
    end
  end

  assign src_ext   = 32'(Src);
  assign src_ok    = src_ext < NSRC;
  assign eval      = (state_q == IDLE) || bus_ready;
  assign idx_d     = mode ? (hi_found ? hi_idx : lo_idx) : Src;
  assign load_d    = eval && (mode ? lo_found : (sel_en && src_ok));
  assign sel_err_d = eval && !mode && sel_en && !src_ok;
  assign bus_d     = src_data[idx_d*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      sel_err_q   <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      grant_q   <= '0;
      sel_err_q <= sel_err_d;
      case (state_q)
        IDLE: if (load_d) state_q <= HOLD;
        HOLD: if (bus_ready && !load_d) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load_d) begin
        bus_q       <= bus_d;
        grant_idx_q <= idx_d;
        grant_q     <= GRANT_ONE << idx_d;
        if (mode) last_q <= idx_d;
      end
    end
  end

  assign Bus       = bus_q;
  assign bus_valid = (state_q == HOLD);
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: default 8-source instance plus a 5-source
// instance for the illegal-select cases.
module tb_bus_arbiter_mux;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [127:0] src_data;
  logic [7:0]   req;
  logic         mode, sel_en, bus_ready;
  logic [2:0]   Src;
  logic [15:0]  Bus;
  logic         bus_valid, sel_err;
  logic [7:0]   grant;
  logic [2:0]   grant_idx;

  logic [79:0]  src_data5;
  logic [4:0]   req5;
  logic         mode5, sel_en5, bus_ready5;
  logic [2:0]   Src5;
  logic [15:0]  Bus5;
  logic         bus_valid5, sel_err5;
  logic [4:0]   grant5;
  logic [2:0]   grant_idx5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter_mux dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .req(req), .mode(mode),
    .Src(Src), .sel_en(sel_en), .bus_ready(bus_ready), .Bus(Bus),
    .bus_valid(bus_valid), .grant(grant), .grant_idx(grant_idx), .sel_err(sel_err)
  );

  bus_arbiter_mux #(.WIDTH(16), .NSRC(5), .SELW(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .src_data(src_data5), .req(req5), .mode(mode5),
    .Src(Src5), .sel_en(sel_en5), .bus_ready(bus_ready5), .Bus(Bus5),
    .bus_valid(bus_valid5), .grant(grant5), .grant_idx(grant_idx5), .sel_err(sel_err5)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (Bus !== 16'h0) begin $display("FAIL reset_bus got %h want 0000", Bus); fails++; end
    tests++;
    if (bus_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus_valid); fails++; end
    tests++;
    if (grant !== 8'h00) begin $display("FAIL reset_grant got %b want 00000000", grant); fails++; end
    tests++;
    if (grant_idx !== 3'd0) begin $display("FAIL reset_idx got %0d want 0", grant_idx); fails++; end
    tests++;
    if (sel_err !== 1'b0) begin $display("FAIL reset_sel_err got %b want 0", sel_err); fails++; end
    tests++;
  endtask

  task automatic test_direct();
    mode = 1'b0; Src = 3'd5; sel_en = 1'b1; bus_ready = 1'b0;
    cyc();
    sel_en = 1'b0;
    if (Bus !== 16'hA5A5) begin $display("FAIL direct_bus got %h want a5a5", Bus); fails++; end
    tests++;
    if (bus_valid !== 1'b1) begin $display("FAIL direct_valid got %b want 1", bus_valid); fails++; end
    tests++;
    if (grant !== 8'b0010_0000) begin $display("FAIL direct_grant got %b want 00100000", grant); fails++; end
    tests++;
    if (grant_idx !== 3'd5) begin $display("FAIL direct_idx got %0d want 5", grant_idx); fails++; end
    tests++;
    cyc();
    if (grant !== 8'h00) begin $display("FAIL direct_grant_pulse got %b want 00000000", grant); fails++; end
    tests++;
    if (bus_valid !== 1'b1) begin $display("FAIL direct_hold_valid got %b want 1", bus_valid); fails++; end
    tests++;
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    if (bus_valid !== 1'b0) begin $display("FAIL direct_consume_valid got %b want 0", bus_valid); fails++; end
    tests++;
    if (Bus !== 16'hA5A5) begin $display("FAIL direct_bus_kept got %h want a5a5", Bus); fails++; end
    tests++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_idx [4];
    exp_idx[0] = 3'd0; exp_idx[1] = 3'd7; exp_idx[2] = 3'd0; exp_idx[3] = 3'd7;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    mode = 1'b1; req = 8'b1000_0001; bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (grant_idx !== exp_idx[k]) begin $display("FAIL rr_idx[%0d] got %0d want %0d", k, grant_idx, exp_idx[k]); fails++; end
      tests++;
      if (grant !== (8'h01 << exp_idx[k])) begin $display("FAIL rr_grant[%0d] got %b want %b", k, grant, 8'h01 << exp_idx[k]); fails++; end
      tests++;
      if (bus_valid !== 1'b1) begin $display("FAIL rr_valid[%0d] got %b want 1", k, bus_valid); fails++; end
      tests++;
      if (Bus !== (16'h1000 + 16'(exp_idx[k]))) begin $display("FAIL rr_bus[%0d] got %h want %h", k, Bus, 16'h1000 + 16'(exp_idx[k])); fails++; end
      tests++;
    end
    req = 8'h00;
    cyc();
    if (bus_valid !== 1'b0) begin $display("FAIL rr_drain_valid got %b want 0", bus_valid); fails++; end
    tests++;
    if (Bus !== 16'h1007) begin $display("FAIL rr_drain_bus got %h want 1007", Bus); fails++; end
    tests++;
    bus_ready = 1'b0;
  endtask

  task automatic test_hold();
    mode = 1'b0; Src = 3'd3; sel_en = 1'b1; bus_ready = 1'b0; req = 8'h00;
    cyc();
    for (int k = 0; k < 4; k++) begin
      req  = (k % 2 == 0) ? 8'hFF : 8'h24;
      Src  = 3'(k + 4);
      mode = (k % 2 == 0);
      cyc();
      if (Bus !== 16'h1234) begin $display("FAIL hold_bus[%0d] got %h want 1234", k, Bus); fails++; end
      tests++;
      if (grant_idx !== 3'd3) begin $display("FAIL hold_idx[%0d] got %0d want 3", k, grant_idx); fails++; end
      tests++;
      if (grant !== 8'h00) begin $display("FAIL hold_grant[%0d] got %b want 00000000", k, grant); fails++; end
      tests++;
      if (bus_valid !== 1'b1) begin $display("FAIL hold_valid[%0d] got %b want 1", k, bus_valid); fails++; end
      tests++;
    end
    mode = 1'b0; sel_en = 1'b0; req = 8'h00; bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    if (bus_valid !== 1'b0) begin $display("FAIL hold_release_valid got %b want 0", bus_valid); fails++; end
    tests++;
  endtask

  // Pointer is 7 from the arbitration run; the direct load of 3 must not move it.
  task automatic test_back_to_back();
    logic [2:0] exp_idx [3];
    exp_idx[0] = 3'd3; exp_idx[1] = 3'd4; exp_idx[2] = 3'd3;
    mode = 1'b1; req = 8'b0001_1000; bus_ready = 1'b0;
    cyc();
    if (grant_idx !== exp_idx[0]) begin $display("FAIL b2b_idx[0] got %0d want %0d", grant_idx, exp_idx[0]); fails++; end
    tests++;
    bus_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      cyc();
      if (grant_idx !== exp_idx[k]) begin $display("FAIL b2b_idx[%0d] got %0d want %0d", k, grant_idx, exp_idx[k]); fails++; end
      tests++;
      if (bus_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d] got %b want 1", k, bus_valid); fails++; end
      tests++;
    end
    req = 8'h00;
    cyc();
    bus_ready = 1'b0;
    if (bus_valid !== 1'b0) begin $display("FAIL b2b_drain_valid got %b want 0", bus_valid); fails++; end
    tests++;
  endtask

  task automatic test_sel_err();
    mode5 = 1'b0; Src5 = 3'd6; sel_en5 = 1'b1; bus_ready5 = 1'b0; req5 = 5'h00;
    cyc();
    sel_en5 = 1'b0;
    if (sel_err5 !== 1'b1) begin $display("FAIL selerr_pulse got %b want 1", sel_err5); fails++; end
    tests++;
    if (bus_valid5 !== 1'b0) begin $display("FAIL selerr_valid got %b want 0", bus_valid5); fails++; end
    tests++;
    cyc();
    if (sel_err5 !== 1'b0) begin $display("FAIL selerr_width got %b want 0", sel_err5); fails++; end
    tests++;
    Src5 = 3'd4; sel_en5 = 1'b1;
    cyc();
    sel_en5 = 1'b0;
    if (Bus5 !== 16'h5004) begin $display("FAIL selerr_load_bus got %h want 5004", Bus5); fails++; end
    tests++;
    if (grant5 !== 5'b10000) begin $display("FAIL selerr_load_grant got %b want 10000", grant5); fails++; end
    tests++;
    if (grant_idx5 !== 3'd4) begin $display("FAIL selerr_load_idx got %0d want 4", grant_idx5); fails++; end
    tests++;
    mode5 = 1'b1; Src5 = 3'd7; sel_en5 = 1'b1; bus_ready5 = 1'b1;
    cyc();
    sel_en5 = 1'b0; bus_ready5 = 1'b0;
    if (sel_err5 !== 1'b0) begin $display("FAIL selerr_arb_mode got %b want 0", sel_err5); fails++; end
    tests++;
    if (bus_valid5 !== 1'b0) begin $display("FAIL selerr_arb_valid got %b want 0", bus_valid5); fails++; end
    tests++;
  endtask

  task automatic test_async_reset();
    mode = 1'b0; Src = 3'd6; sel_en = 1'b1; bus_ready = 1'b0; req = 8'h00;
    cyc();
    sel_en = 1'b0;
    if (Bus !== 16'hBEEF) begin $display("FAIL areset_preload got %h want beef", Bus); fails++; end
    tests++;
    #3;
    rst_n = 1'b0;
    #1;
    if (Bus !== 16'h0) begin $display("FAIL areset_bus got %h want 0000", Bus); fails++; end
    tests++;
    if (bus_valid !== 1'b0) begin $display("FAIL areset_valid got %b want 0", bus_valid); fails++; end
    tests++;
    #1;
    rst_n = 1'b1;
    mode = 1'b1; req = 8'b0000_0100;
    cyc();
    if (grant_idx !== 3'd2) begin $display("FAIL areset_rr_idx got %0d want 2", grant_idx); fails++; end
    tests++;
    if (grant !== 8'b0000_0100) begin $display("FAIL areset_rr_grant got %b want 00000100", grant); fails++; end
    tests++;
    if (bus_valid !== 1'b1) begin $display("FAIL areset_rr_valid got %b want 1", bus_valid); fails++; end
    tests++;
    req = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; mode = 1'b0; sel_en = 1'b0; bus_ready = 1'b0; Src = '0;
    req5 = '0; mode5 = 1'b0; sel_en5 = 1'b0; bus_ready5 = 1'b0; Src5 = '0;
    for (int i = 0; i < 8; i++) src_data[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int i = 0; i < 5; i++) src_data5[i*16 +: 16] = 16'h5000 + 16'(i);
    src_data[5*16 +: 16] = 16'hA5A5;
    #2;
    test_reset();
    cyc();
    test_reset();
    #2;
    rst_n = 1'b1;
    test_direct();
    test_round_robin();
    src_data[3*16 +: 16] = 16'h1234;
    test_hold();
    test_back_to_back();
    test_sel_err();
    src_data[6*16 +: 16] = 16'hBEEF;
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
